// File: rtl/uart_rx_typed_dechunker.sv
// Rebuilds typed chunks from the escaped UART byte stream and holds each
// complete chunk on the outputs until the consumer acknowledges it.
module uart_rx_typed_dechunker #(
    parameter int CONTENT_BUFFER_BYTE_SIZE  = 3,
    parameter int CONTENT_BUFFER_INDEX_SIZE = 32
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  is_rx_done,
    input  logic [7:0]                            rx_data,
    input  logic                                  chunk_ack,
    output logic                                  is_chunk_ready,
    output logic [7:0]                            chunk_type,
    output logic [CONTENT_BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
    output logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    output logic                                  is_chunk_dropped
);

    localparam int IDX = CONTENT_BUFFER_INDEX_SIZE;
    localparam logic [IDX-1:0] MAX_COUNT = IDX'(CONTENT_BUFFER_BYTE_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        HDR_ESC,
        RECEIVING,
        DATA_ESC,
        HOLD
    } state_t;

    state_t                            state, state_n;
    logic [IDX-1:0]                    count, count_n;
    logic [7:0]                        type_n;
    logic [IDX-1:0]                    size_n;
    logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0] bytes_n;
    logic                              ready_n, drop_n;
    logic                              start, store;
    logic [7:0]                        store_byte;

    always_comb begin
        state_n    = state;
        count_n    = count;
        type_n     = chunk_type;
        size_n     = chunk_byte_size;
        bytes_n    = chunk_bytes;
        ready_n    = is_chunk_ready;
        drop_n     = 1'b0;
        start      = 1'b0;
        store      = 1'b0;
        store_byte = rx_data;

        case (state)
            IDLE: begin
                if (is_rx_done && rx_data == 8'h00) state_n = HDR_ESC;
            end
            HDR_ESC: begin
                if (is_rx_done) begin
                    if (rx_data >= 8'h02)      start   = 1'b1;
                    else if (rx_data == 8'h01) state_n = IDLE;
                end
            end
            RECEIVING: begin
                if (is_rx_done) begin
                    if (rx_data == 8'h00) state_n = DATA_ESC;
                    else                  store   = 1'b1;
                end
            end
            DATA_ESC: begin
                if (is_rx_done) begin
                    if (rx_data == 8'h00) begin
                        store      = 1'b1;
                        store_byte = 8'h00;
                    end else if (rx_data == 8'h01) begin
                        state_n = HOLD;
                        size_n  = count;
                        ready_n = 1'b1;
                    end else begin
                        // A new header inside a chunk abandons the partial one.
                        drop_n = 1'b1;
                        start  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (chunk_ack) begin
                    ready_n = 1'b0;
                    state_n = (is_rx_done && rx_data == 8'h00) ? HDR_ESC : IDLE;
                end else if (is_rx_done) begin
                    drop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (start) begin
            state_n = RECEIVING;
            type_n  = rx_data;
            count_n = '0;
            size_n  = '0;
            bytes_n = '0;
        end

        if (store) begin
            if (count == MAX_COUNT) begin
                drop_n  = 1'b1;
                state_n = IDLE;
            end else begin
                for (int i = 0; i < CONTENT_BUFFER_BYTE_SIZE; i++) begin
                    if (count == IDX'(i)) bytes_n[i*8 +: 8] = store_byte;
                end
                count_n = count + 1'b1;
                state_n = RECEIVING;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= IDLE;
            count            <= '0;
            chunk_type       <= '0;
            chunk_byte_size  <= '0;
            chunk_bytes      <= '0;
            is_chunk_ready   <= 1'b0;
            is_chunk_dropped <= 1'b0;
        end else begin
            state            <= state_n;
            count            <= count_n;
            chunk_type       <= type_n;
            chunk_byte_size  <= size_n;
            chunk_bytes      <= bytes_n;
            is_chunk_ready   <= ready_n;
            is_chunk_dropped <= drop_n;
        end
    end

endmodule
